// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue -- circular instruction FIFO between the fetcher and the Decoder.
//
// Holds fetched {inst, pc} pairs and presents the head entry to the Decoder.
// The head is dequeued when the Decoder reports the Dispatcher consumed it.
// A flush (clr_in) empties the queue on the next rising edge.
//
// Optional feature macro: IQ_BYPASS_EN
//   When defined, an empty queue forwards the incoming fetch combinationally
//   to the Decoder. If it is consumed in that same cycle it is never written.
//
// Ports:
//   clk_in, rst_in       clock (rising edge), async active-high reset
//   rdy_in               global ready; low freezes all queue state
//   clr_in               synchronous flush
//   rdy_if_in            fetcher presents inst_if_in / pc_if_in
//   full_if_out          queue holds DEPTH entries
//   almost_full_if_out   free slots <= ALMOST_FULL_GAP
//   rdy_dec_out          head valid, with inst_dec_out / pc_dec_out
//   rdy_dispatch_dec_in  head consumed this cycle
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module inst_queue #(
  parameter int IQ_SIZE_LOG     = 4,
  parameter int ALMOST_FULL_GAP = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clr_in,
  input  logic                   rdy_if_in,
  input  logic [31:0]            inst_if_in,
  input  logic [`ADDR_WIDTH-1:0] pc_if_in,
  output logic                   full_if_out,
  output logic                   almost_full_if_out,
  output logic                   rdy_dec_out,
  output logic [31:0]            inst_dec_out,
  output logic [`ADDR_WIDTH-1:0] pc_dec_out,
  input  logic                   rdy_dispatch_dec_in
);

  localparam int DEPTH = 1 << IQ_SIZE_LOG;
  localparam logic [IQ_SIZE_LOG:0] DEPTH_C = (IQ_SIZE_LOG+1)'(DEPTH);
  localparam logic [IQ_SIZE_LOG:0] GAP_C   = (IQ_SIZE_LOG+1)'(ALMOST_FULL_GAP);
  localparam logic [IQ_SIZE_LOG:0] ONE_C   = (IQ_SIZE_LOG+1)'(1);
  localparam logic [IQ_SIZE_LOG-1:0] PINC  = IQ_SIZE_LOG'(1);

  logic [31:0]            r_inst [DEPTH];
  logic [`ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [IQ_SIZE_LOG-1:0] r_head, r_tail;
  logic [IQ_SIZE_LOG:0]   r_count;

  logic w_full, w_empty, w_push, w_pop, w_byp, w_byp_take, w_wr;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = rdy_in & rdy_if_in & ~w_full;
  assign w_pop   = rdy_in & rdy_dispatch_dec_in & ~w_empty;

`ifdef IQ_BYPASS_EN
  // Forward the fetch straight through when there is nothing queued ahead.
  assign w_byp      = w_empty & rdy_if_in & rdy_in & ~clr_in;
  assign w_byp_take = w_byp & rdy_dispatch_dec_in;
`else
  assign w_byp      = 1'b0;
  assign w_byp_take = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never lands in storage.
  assign w_wr = w_push & ~w_byp_take & ~clr_in;

  assign full_if_out        = w_full;
  assign almost_full_if_out = (DEPTH_C - r_count) <= GAP_C;
  assign rdy_dec_out        = ~w_empty | w_byp;

  always_comb begin
    inst_dec_out = '0;
    pc_dec_out   = '0;
    if (!w_empty) begin
      inst_dec_out = r_inst[r_head];
      pc_dec_out   = r_pc[r_head];
    end else if (w_byp) begin
      inst_dec_out = inst_if_in;
      pc_dec_out   = pc_if_in;
    end
  end

  // Storage is not reset; only entries between head and tail are ever read.
  always_ff @(posedge clk_in) begin
    if (w_wr) begin
      r_inst[r_tail] <= inst_if_in;
      r_pc[r_tail]   <= pc_if_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clr_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_tail <= r_tail + PINC;
      if (w_pop) r_head <= r_head + PINC;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_inst_queue;
  localparam int AW = `ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;
  logic          rdy_if = 1'b0;
  logic [31:0]   inst_if = '0;
  logic [AW-1:0] pc_if = '0;
  logic          rdy_disp = 1'b0;
  logic          full, afull, rdy_dec;
  logic [31:0]   inst_dec;
  logic [AW-1:0] pc_dec;

  inst_queue #(.IQ_SIZE_LOG(4), .ALMOST_FULL_GAP(2)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr),
    .rdy_if_in(rdy_if), .inst_if_in(inst_if), .pc_if_in(pc_if),
    .full_if_out(full), .almost_full_if_out(afull),
    .rdy_dec_out(rdy_dec), .inst_dec_out(inst_dec), .pc_dec_out(pc_dec),
    .rdy_dispatch_dec_in(rdy_disp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic [31+AW:0] exp_q[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: whenever the Decoder consumes the head, it must be the oldest
  // accepted fetch still outstanding.
  always @(negedge clk) begin
    if (!rst && rdy && !clr && rdy_disp && rdy_dec) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL head_unexpected: got %h@%h expected none", inst_dec, pc_dec);
      end else begin
        logic [31+AW:0] e;
        e = exp_q.pop_front();
        chk("head_inst", 64'(inst_dec), 64'(e[31+AW:AW]));
        chk("head_pc",   64'(pc_dec),   64'(e[AW-1:0]));
      end
    end
  end

  // One clock of stimulus, driven just after a rising edge.
  task automatic step(input bit push, input logic [31:0] iv, input logic [AW-1:0] pv,
                      input bit pop, input bit r = 1'b1, input bit c = 1'b0);
    bit acc_push, acc_pop, byp;
    rdy_if = push; inst_if = iv; pc_if = pv; rdy_disp = pop; rdy = r; clr = c;
    acc_push = r && !c && push && (m_cnt < 16);
    acc_pop  = r && !c && pop && (m_cnt > 0);
    byp = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = r && !c && push && (m_cnt == 0);
`endif
    if (c) exp_q.delete();
    else if (acc_push) exp_q.push_back({iv, pv});
    @(negedge clk);
    chk("full",    64'(full),    64'(m_cnt == 16));
    chk("afull",   64'(afull),   64'((16 - m_cnt) <= 2));
    chk("rdy_dec", 64'(rdy_dec), 64'(m_cnt != 0 || byp));
    @(posedge clk);
    if (c) m_cnt = 0;
    else if (byp && pop) m_cnt = m_cnt;
    else m_cnt = m_cnt + int'(acc_push) - int'(acc_pop);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  64'(rdy_dec),  0);
    chk("rst_inst", 64'(inst_dec), 0);
    chk("rst_pc",   64'(pc_dec),   0);
    chk("rst_full", 64'(full),     0);
    chk("rst_af",   64'(afull),    0);
    rst = 1'b0;
    idle();

    // Three pushes, then three pops
    step(1, 32'h00000013, AW'('h0), 0);
    step(1, 32'h00100093, AW'('h4), 0);
    chk("first_head", 64'(inst_dec), 64'h00000013);
    step(1, 32'h00200113, AW'('h8), 0);
    repeat (3) step(0, '0, '0, 1);
    idle();
    chk("empty_after3", 64'(rdy_dec), 0);

    // Fill to 16, 17th dropped, drain 16
    for (int i = 0; i < 16; i++) step(1, 32'h1000 + 32'(i), AW'(32'h400 + 4*i), 0);
    chk("full16", 64'(full), 1);
    step(1, 32'hBAD0BAD0, AW'('hBAD), 0);
    for (int i = 0; i < 16; i++) step(0, '0, '0, 1);
    idle();
    chk("empty_after16", 64'(rdy_dec), 0);

    // Full with simultaneous push+pop: push is rejected
    for (int i = 0; i < 16; i++) step(1, 32'h2000 + 32'(i), AW'(32'h800 + 4*i), 0);
    step(1, 32'hBAD1BAD1, AW'('hBAD1), 1);
    chk("fullpp_full",  64'(full),  0);
    chk("fullpp_afull", 64'(afull), 1);
    step(1, 32'h20AA, AW'('h8AA), 1);
    chk("pp15_full", 64'(full), 0);
    for (int i = 0; i < 15; i++) step(0, '0, '0, 1);
    idle();
    chk("empty_after15", 64'(rdy_dec), 0);

    // Wrap-around: 12 interleaved push/pop pairs, then 10 pushes
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h3000 + 32'(i), AW'(32'hC00 + 4*i), 0);
      step(0, '0, '0, 1);
    end
    for (int i = 0; i < 10; i++) step(1, 32'h4000 + 32'(i), AW'(32'h1000 + 4*i), 0);
    for (int i = 0; i < 10; i++) step(0, '0, '0, 1);
    idle();

    // Flush together with push and pop
    for (int i = 0; i < 5; i++) step(1, 32'h5000 + 32'(i), AW'(32'h1400 + 4*i), 0);
    step(1, 32'hBAD2BAD2, AW'('hBAD2), 1, 1, 1);
    idle();
    chk("clr_rdy", 64'(rdy_dec), 0);
    step(1, 32'hDEADBEEF, AW'('h100), 0);
    chk("clr_head_inst", 64'(inst_dec), 64'hDEADBEEF);
    chk("clr_head_pc",   64'(pc_dec),   64'h100);
    step(0, '0, '0, 1);
    idle();

    // rdy_in low freezes state
    for (int i = 0; i < 3; i++) step(1, 32'h6000 + 32'(i), AW'(32'h1800 + 4*i), 0);
    repeat (4) step(1, 32'hBAD3BAD3, AW'('hBAD3), 1, 0);
    chk("hold_head", 64'(inst_dec), 64'h6000);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1);
    idle();
    chk("empty_after_hold", 64'(rdy_dec), 0);

    // Asynchronous reset with 7 entries queued
    for (int i = 0; i < 7; i++) step(1, 32'h7000 + 32'(i), AW'(32'h1C00 + 4*i), 0);
    chk("pre_rst_rdy", 64'(rdy_dec), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdy",  64'(rdy_dec),  0);
    chk("async_rst_inst", 64'(inst_dec), 0);
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    chk("post_rst_rdy", 64'(rdy_dec), 0);

`ifdef IQ_BYPASS_EN
    // Bypass: push and pop on an empty queue, consumed without being stored
    rdy_if = 1; inst_if = 32'hCAFEF00D; pc_if = AW'('h200); rdy_disp = 1; rdy = 1; clr = 0;
    #1;
    chk("byp_inst", 64'(inst_dec), 64'hCAFEF00D);
    chk("byp_pc",   64'(pc_dec),   64'h200);
    step(1, 32'hCAFEF00D, AW'('h200), 1);
    idle();
    chk("byp_count0", 64'(rdy_dec), 0);
`else
    // No bypass: an empty queue stays not-ready during the push cycle
    rdy_if = 1; inst_if = 32'hCAFEF00D; pc_if = AW'('h200); rdy_disp = 0; rdy = 1; clr = 0;
    #1;
    chk("nobyp_rdy", 64'(rdy_dec), 0);
    step(1, 32'hCAFEF00D, AW'('h200), 0);
    step(0, '0, '0, 1);
    idle();
`endif

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
